// File: rtl/ram_arb_ctrl_if.sv
// Client and RAM-side signal bundle of ram_arb_ctrl.
// slave is the controller's view, master is the clients' plus RAM's view.
interface ram_arb_ctrl_if #(
  parameter int unsigned DW = 4,
  parameter int unsigned AW = 3
);
  logic          init_done;
  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_gnt;
  logic          a_rvalid;
  logic [DW-1:0] a_rdata;
  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_gnt;
  logic          b_rvalid;
  logic [DW-1:0] b_rdata;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  modport slave (
    output init_done,
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output ram_en, ram_addr, ram_din,
    input  ram_dout
  );

  modport master (
    input  init_done,
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  ram_en, ram_addr, ram_din,
    output ram_dout
  );
endinterface

// File: rtl/ram_arb_ctrl.sv
// Owner of a single-port RAM: clears it after reset, then round-robins A/B accesses
// with a fixed one-cycle read latency.
module ram_arb_ctrl #(
  parameter int unsigned   DW       = 4,
  parameter int unsigned   AW       = 3,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input logic           clk,
  input logic           rst_n,
  ram_arb_ctrl_if.slave bus
);
  typedef enum logic {StInit, StRun} state_e;

  localparam logic [AW-1:0] LastAddr = {AW{1'b1}};
  localparam logic          PtrA     = 1'b0;
  localparam logic          PtrB     = 1'b1;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          ptr_q, ptr_d;
  logic          a_rvalid_q, a_rvalid_d;
  logic          b_rvalid_q, b_rvalid_d;
  logic          a_gnt, b_gnt;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    a_gnt    = 1'b0;
    b_gnt    = 1'b0;
    ram_en   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    unique case (state_q)
      StInit: begin
        ram_en   = 1'b1;
        ram_addr = cnt_q;
        ram_din  = INIT_VAL;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LastAddr) state_d = StRun;
      end
      StRun: begin
        // A wins when alone or when the pointer favours it; B takes whatever A does not.
        a_gnt = bus.a_req & (~bus.b_req | (ptr_q == PtrA));
        b_gnt = bus.b_req & ~a_gnt;
        if (a_gnt) begin
          ram_en   = bus.a_we;
          ram_addr = bus.a_addr;
          ram_din  = bus.a_wdata;
          ptr_d    = PtrB;
        end else if (b_gnt) begin
          ram_en   = bus.b_we;
          ram_addr = bus.b_addr;
          ram_din  = bus.b_wdata;
          ptr_d    = PtrA;
        end
      end
    endcase
  end

  assign a_rvalid_d = a_gnt & ~bus.a_we;
  assign b_rvalid_d = b_gnt & ~bus.b_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StInit;
      cnt_q      <= '0;
      ptr_q      <= PtrA;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
    end
  end

  assign bus.init_done = (state_q == StRun);
  assign bus.a_gnt     = a_gnt;
  assign bus.b_gnt     = b_gnt;
  assign bus.a_rvalid  = a_rvalid_q;
  assign bus.b_rvalid  = b_rvalid_q;
  assign bus.a_rdata   = a_rvalid_q ? bus.ram_dout : '0;
  assign bus.b_rdata   = b_rvalid_q ? bus.ram_dout : '0;
  assign bus.ram_en    = ram_en;
  assign bus.ram_addr  = ram_addr;
  assign bus.ram_din   = ram_din;
endmodule

// File: tb/tb_ram_arb_ctrl.sv
// Bench for ram_arb_ctrl: RAM model, per-cycle reference-model compare, directed and
// random stimulus.
module tb_ram_arb_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  ram_arb_ctrl_if #(.DW(4), .AW(3)) bus ();

  ram_arb_ctrl #(.DW(4), .AW(3), .INIT_VAL(4'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 8x4 single-port RAM without reset; dout only changes on read edges.
  logic [3:0] ram_mem [8];
  always @(posedge clk) begin
    if (bus.ram_en) ram_mem[bus.ram_addr] <= bus.ram_din;
    else            bus.ram_dout <= ram_mem[bus.ram_addr];
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: cycles since reset release, arbitration pointer, memory image,
  // and the response due in the next cycle on each channel.
  int         m_since = 0;
  bit         m_ptr_b = 1'b0;
  bit         m_arv = 1'b0, m_brv = 1'b0;
  logic [3:0] m_ard = '0, m_brd = '0;
  logic [3:0] m_mem [8];
  bit         ga, gb;

  always begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_a_gnt", int'(bus.a_gnt), 0);
      chk("rst_b_gnt", int'(bus.b_gnt), 0);
      chk("rst_a_rvalid", int'(bus.a_rvalid), 0);
      chk("rst_b_rvalid", int'(bus.b_rvalid), 0);
      chk("rst_init_done", int'(bus.init_done), 0);
      m_since = 0;
      m_ptr_b = 1'b0;
      m_arv   = 1'b0;
      m_brv   = 1'b0;
    end else begin
      chk("init_done", int'(bus.init_done), int'(m_since >= 8));
      chk("a_rvalid", int'(bus.a_rvalid), int'(m_arv));
      chk("b_rvalid", int'(bus.b_rvalid), int'(m_brv));
      chk("a_rdata", int'(bus.a_rdata), m_arv ? int'(m_ard) : 0);
      chk("b_rdata", int'(bus.b_rdata), m_brv ? int'(m_brd) : 0);
      if (m_since < 8) begin
        chk("init_a_gnt", int'(bus.a_gnt), 0);
        chk("init_b_gnt", int'(bus.b_gnt), 0);
        chk("init_ram_en", int'(bus.ram_en), 1);
        chk("init_ram_addr", int'(bus.ram_addr), m_since);
        chk("init_ram_din", int'(bus.ram_din), 0);
        m_mem[3'(m_since)] = 4'h0;
        m_arv = 1'b0;
        m_brv = 1'b0;
      end else begin
        ga = bus.a_req && (!bus.b_req || !m_ptr_b);
        gb = bus.b_req && !ga;
        chk("a_gnt", int'(bus.a_gnt), int'(ga));
        chk("b_gnt", int'(bus.b_gnt), int'(gb));
        if (ga) begin
          chk("ram_en", int'(bus.ram_en), int'(bus.a_we));
          chk("ram_addr", int'(bus.ram_addr), int'(bus.a_addr));
          chk("ram_din", int'(bus.ram_din), int'(bus.a_wdata));
          m_ard = m_mem[bus.a_addr];
          if (bus.a_we) m_mem[bus.a_addr] = bus.a_wdata;
          m_ptr_b = 1'b1;
        end else if (gb) begin
          chk("ram_en", int'(bus.ram_en), int'(bus.b_we));
          chk("ram_addr", int'(bus.ram_addr), int'(bus.b_addr));
          chk("ram_din", int'(bus.ram_din), int'(bus.b_wdata));
          m_brd = m_mem[bus.b_addr];
          if (bus.b_we) m_mem[bus.b_addr] = bus.b_wdata;
          m_ptr_b = 1'b0;
        end else begin
          chk("idle_ram_en", int'(bus.ram_en), 0);
          chk("idle_ram_addr", int'(bus.ram_addr), 0);
          chk("idle_ram_din", int'(bus.ram_din), 0);
        end
        m_arv = ga && !bus.a_we;
        m_brv = gb && !bus.b_we;
      end
      m_since++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit ch, input bit req, input bit we, input logic [2:0] addr,
                       input logic [3:0] wd);
    if (ch) begin
      bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
    end else begin
      bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
    end
  endtask

  // Issues one access, holds it until granted; returns grant cycle index and read data.
  task automatic access(input bit ch, input bit we, input logic [2:0] addr,
                        input logic [3:0] wd, output logic [3:0] rd, output int gcyc);
    gcyc = -1;
    rd   = '0;
    drive(ch, 1'b1, we, addr, wd);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ch ? bus.b_gnt : bus.a_gnt) begin
        gcyc = i;
        break;
      end
      step();
    end
    if (gcyc < 0) chk("gnt_timeout", 0, 1);
    step();
    drive(ch, 1'b0, 1'b0, 3'd0, 4'd0);
    if (gcyc >= 0 && !we) begin
      @(negedge clk);
      chk("read_latency", int'(ch ? bus.b_rvalid : bus.a_rvalid), 1);
      rd = ch ? bus.b_rdata : bus.a_rdata;
      step();
    end
  endtask

  task automatic init_latency();
    int n;
    n = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.init_done) begin
        n = k;
        break;
      end
      step();
    end
    chk("init_latency", n, 8);
    step();
  endtask

  task automatic read_all_zero(input string nm);
    logic [3:0] rd;
    int         g;
    for (int i = 0; i < 8; i++) begin
      access(1'b0, 1'b0, 3'(i), 4'h0, rd, g);
      chk(nm, int'(rd), 0);
    end
  endtask

  task automatic rnd_chan(input bit ch, input bit granted);
    bit cur;
    cur = ch ? bus.b_req : bus.a_req;
    if (cur && !granted && $urandom_range(15) != 0) return;
    if ($urandom_range(9) < 6)
      drive(ch, 1'b1, 1'($urandom_range(1)), 3'($urandom_range(7)), 4'($urandom_range(15)));
    else
      drive(ch, 1'b0, 1'b0, 3'd0, 4'd0);
  endtask

  initial begin
    logic [3:0] rd;
    int         g;
    bit         sa, sb;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    drive(1'b1, 1'b0, 1'b0, 3'd0, 4'd0);
    step();
    step();
    step();
    rst_n = 1'b1;
    init_latency();
    read_all_zero("clear_rd");

    access(1'b0, 1'b1, 3'd5, 4'hA, rd, g);
    chk("a_wr5_gnt", int'(g >= 0), 1);
    access(1'b0, 1'b0, 3'd5, 4'h0, rd, g);
    chk("a_rd5", int'(rd), 'hA);

    access(1'b1, 1'b1, 3'd4, 4'h7, rd, g);
    access(1'b0, 1'b0, 3'd4, 4'h0, rd, g);
    chk("raw_wait", g, 0);
    chk("raw_rd4", int'(rd), 7);

    // After these two writes the pointer is back on A.
    access(1'b0, 1'b1, 3'd1, 4'h3, rd, g);
    access(1'b1, 1'b1, 3'd2, 4'hC, rd, g);
    drive(1'b0, 1'b1, 1'b0, 3'd1, 4'h0);
    drive(1'b1, 1'b1, 1'b0, 3'd2, 4'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 4) begin
        chk("cont_a_gnt", int'(bus.a_gnt), int'(k % 2 == 0));
        chk("cont_b_gnt", int'(bus.b_gnt), int'(k % 2 == 1));
      end
      if (k > 0) begin
        chk("cont_a_rv", int'(bus.a_rvalid), int'(k % 2 == 1));
        chk("cont_b_rv", int'(bus.b_rvalid), int'(k % 2 == 0));
        chk("cont_data", int'(k % 2 == 1 ? bus.a_rdata : bus.b_rdata), k % 2 == 1 ? 3 : 'hC);
      end
      step();
      if (k == 3) begin
        drive(1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 4'd0);
      end
    end

    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    access(1'b0, 1'b1, 3'd0, 4'hF, rd, g);
    chk("init_req_gnt_cycle", g, 8);
    access(1'b0, 1'b0, 3'd0, 4'h0, rd, g);
    chk("init_req_rd0", int'(rd), 'hF);
    access(1'b0, 1'b0, 3'd1, 4'h0, rd, g);
    chk("init_req_rd1", int'(rd), 0);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      sa = bus.a_gnt;
      sb = bus.b_gnt;
      step();
      rnd_chan(1'b0, sa);
      rnd_chan(1'b1, sb);
    end
    drive(1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    drive(1'b1, 1'b0, 1'b0, 3'd0, 4'd0);
    step();
    step();

    access(1'b0, 1'b1, 3'd5, 4'hA, rd, g);
    drive(1'b0, 1'b1, 1'b0, 3'd5, 4'h0);
    g = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.a_gnt) begin
        g = i;
        break;
      end
      step();
    end
    chk("mid_rd_gnt", int'(g >= 0), 1);
    step();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    chk("mid_rv_before_rst", int'(bus.a_rvalid), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rv_dropped", int'(bus.a_rvalid), 0);
    step();
    step();
    rst_n = 1'b1;
    init_latency();
    read_all_zero("reclear_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1);
  end
endmodule
